// File: rtl/pe_result_drain.sv
// Result drain for the systolic PE array: snapshots the accumulator field on capture,
// pulses an accumulator clear, and streams the snapshot out one PE row per beat.
module pe_result_drain #(
    parameter int N     = 8,
    parameter int M     = N,
    parameter int X     = 6,
    parameter int Y     = 24,
    parameter int ROW_W = (X > 1) ? $clog2(X) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cap,
    input  logic [Y*X*M-1:0]   D,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [Y*M-1:0]     out_data,
    output logic [ROW_W-1:0]   out_row,
    output logic               out_last,
    output logic               sn_clr,
    output logic               busy,
    output logic               overrun
);

    localparam int RowBits = Y * M;
    localparam logic [ROW_W-1:0] LastRow = ROW_W'(X - 1);

    typedef enum logic {StIdle, StSend} state_e;

    state_e             state_q, state_d;
    logic [Y*X*M-1:0]   snap_q, snap_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               sn_clr_q, sn_clr_d;
    logic               overrun_q, overrun_d;

    logic               last_xfer;
    logic               accept;
    logic [RowBits-1:0] rows [X];

    always_comb begin
        // A capture is taken from idle, or on the very edge the final row leaves.
        last_xfer = (state_q == StSend) && out_ready && (row_q == LastRow);
        accept    = cap && ((state_q == StIdle) || last_xfer);

        state_d   = state_q;
        snap_d    = snap_q;
        row_d     = row_q;
        sn_clr_d  = accept;
        overrun_d = overrun_q | (cap && (state_q == StSend) && !last_xfer);

        if (accept) begin
            snap_d  = D;
            row_d   = '0;
            state_d = StSend;
        end else if ((state_q == StSend) && out_ready) begin
            if (row_q == LastRow) begin
                state_d = StIdle;
                row_d   = '0;
            end else begin
                row_d = row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            snap_q    <= '0;
            row_q     <= '0;
            sn_clr_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            row_q     <= row_d;
            sn_clr_q  <= sn_clr_d;
            overrun_q <= overrun_d;
        end
    end

    // Row 0 is the most significant slice of the field.
    always_comb begin
        for (int r = 0; r < X; r++) begin
            rows[r] = snap_q[(X-r)*RowBits-1 -: RowBits];
        end
    end

    assign out_valid = (state_q == StSend);
    assign busy      = (state_q == StSend);
    assign out_row   = row_q;
    assign out_last  = (state_q == StSend) && (row_q == LastRow);
    assign out_data  = rows[row_q];
    assign sn_clr    = sn_clr_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/pe_result_drain.md
Name: pe_result_drain

Overview:
- Read side of the systolic PE array's result bus.
- Snapshots the full accumulator field D (X rows × Y columns × M bits) on a capture request.
- Issues a one-cycle accumulator-clear pulse back toward the array.
- Streams the snapshot out one PE row per beat over a valid/ready interface, so downstream logic never reads the wide D bus directly.

Parameters:
- N, 8, operand width of the PE array (informational; kept for parameter-list parity with the array).
- M, N, result width per PE.
- X, 6, number of PE rows (beats per drain).
- Y, 24, number of PEs per row (lanes per beat).
- ROW_W, (X>1 ? $clog2(X) : 1), width of the row index (derived; not to be overridden).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cap  input  1  one-cycle capture request: the array's results are final this cycle.
- D  input  Y*X*M  accumulator field from the PE array; row r occupies D[(Y*X*M - r*Y*M)-1 : (Y*X*M - r*Y*M) - Y*M], so row 0 is the top slice.
- out_ready  input  1  downstream ready.
- out_valid  output  1  beat valid.
- out_data  output  Y*M  one PE row of results.
- out_row  output  ROW_W  index of the row in out_data (0..X-1).
- out_last  output  1  high with the beat for row X-1.
- sn_clr  output  1  one-cycle pulse clearing/restarting the array's accumulators after the snapshot is taken.
- busy  output  1  snapshot held and not fully drained.
- overrun  output  1  sticky: a capture was dropped.

Behaviour:
- Reset values (rst high at an edge): out_valid=0, out_row=0, out_last=0, out_data=0, sn_clr=0, busy=0, overrun=0, snapshot register=0, FSM=IDLE. Reset mid-drain aborts the drain; no further beats are emitted.
- FSM states: IDLE, SEND.
- IDLE: cap=1 at edge t registers D into the snapshot and moves to SEND with row=0.
  - After edge t: out_valid=1, busy=1, sn_clr=1 for exactly one cycle.
  - Latency from cap to first valid beat is 1 cycle.
- SEND:
  - out_data = snapshot slice for out_row; out_last = (out_row == X-1).
  - Transfer occurs when out_valid & out_ready at an edge.
  - On a transfer with row < X-1: row increments.
  - While out_valid=1 and out_ready=0: out_data, out_row and out_last stay stable, and out_valid stays high.
  - On a transfer of the last row with cap=0: go to IDLE; out_valid=0, busy=0 after the edge.
  - On a transfer of the last row with cap=1 in the same cycle: take a new snapshot and stay in SEND with row=0.
    - Back-to-back drain; no bubble.
    - sn_clr pulses again.
- cap in SEND other than on a last-row transfer cycle: ignored.
  - Snapshot unchanged; no sn_clr.
  - overrun set to 1 and held until rst.
- cap in IDLE while rst=1: rst wins; nothing is captured.
- sn_clr is high only in the cycle after an accepted capture; never two consecutive cycles unless two captures are accepted on consecutive edges. Consecutive accepts are only possible when X=1.
- X=1: every beat is both row 0 and last.
- D is sampled only at the capture edge; later changes to D do not affect out_data.
- No arithmetic; data passes unmodified. Width of out_data is exactly Y*M.

Test Plan:
- Basic drain (X=2, Y=2, M=8):
  - Stimulus: D=32'hAABB_CCDD, cap pulse, out_ready=1.
  - Required: beat 1 cycle later = 16'hAABB, row 0, last 0; next cycle 16'hCCDD, row 1, last 1.
  - Required: sn_clr high only in the first beat cycle; busy low after the second beat.
- Backpressure (same config):
  - Stimulus: out_ready=0 for 3 cycles after the first beat appears.
  - Required: out_data held at 16'hAABB, row 0, valid high for all 3 cycles; drain completes after ready rises.
  - Stimulus: change D to 32'h1111_2222 during the stall.
  - Required: output still AABB then CCDD.
- Overrun:
  - Stimulus: second cap during row-0 beat.
  - Required: ignored; stream stays AABB, CCDD; overrun=1 and stays 1 until rst.
- Back-to-back:
  - Stimulus: cap coincident with the row-1 transfer, new D=32'h0102_0304.
  - Required: next cycle beat 16'h0102 row 0, no idle gap, sn_clr pulses, overrun stays 0.
- Reset mid-drain:
  - Stimulus: assert rst during the row-0 beat.
  - Required: next cycle out_valid=0, busy=0, out_data=0, out_row=0, overrun=0; subsequent cap restarts normally at row 0.
- Default params (X=6, Y=24, M=8):
  - Stimulus: each PE result = row*24+col.
  - Required: 6 beats with rows 0..5; out_last only on beat 5; lane ordering matches the D slice mapping.
